// File: rtl/stb_occ_mon.sv
// stb_occ_mon: store-buffer occupancy checker for the hardware threads of one core.
// Every cycle it watches each thread's STB entry count for overflow and for count
// jumps larger than a legal step. It keeps per-thread high-water marks, sticky
// error flags and a saturating error counter. Error reports are registered.
module stb_occ_mon #(
   parameter int NUM_THR   = 4,
   parameter int CNT_W     = 4,
   parameter int MAX_ENT   = 8,
   parameter int MAX_STEP  = 1,
   parameter int BLANK_CYC = 1,
   parameter int ERRCNT_W  = 16,
   localparam int TID_W    = (NUM_THR > 1) ? $clog2(NUM_THR) : 1
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic                     enable,
   input  logic [9:0]               coreid,
   input  logic [NUM_THR*CNT_W-1:0] stb_cnt,
   input  logic [NUM_THR-1:0]       stb_rst,
   input  logic                     hwm_clr,
   output logic                     err_vld,
   output logic [TID_W-1:0]         err_thr,
   output logic [1:0]               err_code,
   output logic [NUM_THR-1:0]       err_sticky,
   output logic [ERRCNT_W-1:0]      err_cnt,
   output logic [NUM_THR*CNT_W-1:0] hwm
);

   // The blanking counter only has to hold BLANK_CYC.
   localparam int BLK_W = $clog2(BLANK_CYC + 1);
   // popcount(fail) can reach NUM_THR.
   localparam int PC_W  = $clog2(NUM_THR + 1);
   // The extra top bits of the error sum reveal when the counter would pass all-ones.
   localparam int SUM_W = ERRCNT_W + PC_W;

   localparam logic [31:0] MAX_ENT_U  = MAX_ENT;
   localparam logic [31:0] MAX_STEP_U = MAX_STEP;

   logic [NUM_THR-1:0][CNT_W-1:0] r_prevCnt;
   logic [NUM_THR-1:0]            r_prevVld;
   logic [NUM_THR-1:0][BLK_W-1:0] r_blankCtr;
   logic                          r_errVld;
   logic [TID_W-1:0]              r_errThr;
   logic [1:0]                    r_errCode;
   logic [NUM_THR-1:0]            r_errSticky;
   logic [ERRCNT_W-1:0]           r_errCnt;
   logic [NUM_THR-1:0][CNT_W-1:0] r_hwm;

   logic [NUM_THR-1:0][CNT_W-1:0] w_cnt;
   logic [NUM_THR-1:0][CNT_W:0]   w_diff;
   logic [NUM_THR-1:0]            w_active;
   logic [NUM_THR-1:0]            w_ovfl;
   logic [NUM_THR-1:0]            w_step;
   logic [NUM_THR-1:0]            w_fail;
   logic [TID_W-1:0]              w_selThr;
   logic [1:0]                    w_selCode;
   logic [PC_W-1:0]               w_failCnt;
   logic [SUM_W-1:0]              w_sum;
   logic [ERRCNT_W-1:0]           w_nextErrCnt;

   // Per-thread classification: unpack counts, work out the activity window and the violations.
   always_comb begin
      w_cnt    = '0;
      w_diff   = '0;
      w_active = '0;
      w_ovfl   = '0;
      w_step   = '0;
      w_fail   = '0;
      for (int t = 0; t < NUM_THR; t++) begin
         w_cnt[t]    = stb_cnt[t*CNT_W +: CNT_W];
         w_diff[t]   = (w_cnt[t] >= r_prevCnt[t]) ?
                       ({1'b0, w_cnt[t]} - {1'b0, r_prevCnt[t]}) :
                       ({1'b0, r_prevCnt[t]} - {1'b0, w_cnt[t]});
         w_active[t] = !stb_rst[t] && (r_blankCtr[t] == '0);
         w_ovfl[t]   = w_active[t] && (32'(w_cnt[t]) > MAX_ENT_U);
         w_step[t]   = w_active[t] && r_prevVld[t] && (32'(w_diff[t]) > MAX_STEP_U);
         w_fail[t]   = enable && (w_ovfl[t] || w_step[t]);
      end
   end

   // Choose the lowest failing thread, count the failures and form the saturated counter value.
   always_comb begin
      w_selThr  = '0;
      w_selCode = '0;
      w_failCnt = '0;
      for (int t = NUM_THR - 1; t >= 0; t--) begin
         if (w_fail[t]) begin
            w_selThr  = TID_W'(t);
            w_selCode = {w_step[t], w_ovfl[t]};
         end
      end
      for (int t = 0; t < NUM_THR; t++) begin
         w_failCnt = w_failCnt + PC_W'(w_fail[t]);
      end
      w_sum        = SUM_W'(r_errCnt) + SUM_W'(w_failCnt);
      w_nextErrCnt = (|w_sum[SUM_W-1:ERRCNT_W]) ? '1 : w_sum[ERRCNT_W-1:0];
   end

   // Per-thread history: previous count, its validity and the post-reset blanking countdown.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_prevCnt <= '0;
         r_prevVld <= '0;
         for (int t = 0; t < NUM_THR; t++) begin
            r_blankCtr[t] <= BLK_W'(BLANK_CYC);
         end
      end else begin
         for (int t = 0; t < NUM_THR; t++) begin
            r_prevCnt[t] <= w_cnt[t];
            if (stb_rst[t]) begin
               r_prevVld[t]  <= 1'b0;
               r_blankCtr[t] <= BLK_W'(BLANK_CYC);
            end else begin
               r_prevVld[t] <= 1'b1;
               if (r_blankCtr[t] != '0) begin
                  r_blankCtr[t] <= r_blankCtr[t] - BLK_W'(1);
               end
            end
         end
      end
   end

   // Registered error report, sticky flags and saturating error counter.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_errVld    <= 1'b0;
         r_errThr    <= '0;
         r_errCode   <= '0;
         r_errSticky <= '0;
         r_errCnt    <= '0;
      end else begin
         r_errVld    <= |w_fail;
         r_errThr    <= w_selThr;
         r_errCode   <= w_selCode;
         r_errSticky <= r_errSticky | w_fail;
         r_errCnt    <= w_nextErrCnt;
      end
   end

   // High-water marks follow active threads whatever enable says; a clear request wins.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_hwm <= '0;
      end else if (hwm_clr) begin
         r_hwm <= '0;
      end else begin
         for (int t = 0; t < NUM_THR; t++) begin
            if (w_active[t] && (w_cnt[t] > r_hwm[t])) begin
               r_hwm[t] <= w_cnt[t];
            end
         end
      end
   end

   assign err_vld    = r_errVld;
   assign err_thr    = r_errThr;
   assign err_code   = r_errCode;
   assign err_sticky = r_errSticky;
   assign err_cnt    = r_errCnt;
   assign hwm        = r_hwm;

`ifndef SYNTHESIS
   // Simulation log of each reported error event.
   always @(posedge clk) begin
      if (rst_l && r_errVld) begin
         $display("[stb_occ_mon] t=%0t core=%0d thr=%0d code=%b cnt=%0d",
                  $time, coreid, r_errThr, r_errCode, r_errCnt);
      end
   end
`endif

endmodule

// File: tb/tb_stb_occ_mon.sv
// tb_stb_occ_mon: directed bench for stb_occ_mon with hand-computed expectations.
// Two instances share the stimulus: one with default parameters and one with a
// 4-bit error counter so that saturation can be observed.
module tb_stb_occ_mon;

   logic        clock;
   logic        resetL;
   logic        enable;
   logic [9:0]  coreId;
   logic [15:0] stbCnt;
   logic [3:0]  stbRst;
   logic        hwmClr;

   logic        errVld;
   logic [1:0]  errThr;
   logic [1:0]  errCode;
   logic [3:0]  errSticky;
   logic [15:0] errCnt;
   logic [15:0] hwm;

   logic        satErrVld;
   logic [1:0]  satErrThr;
   logic [1:0]  satErrCode;
   logic [3:0]  satErrSticky;
   logic [3:0]  satErrCnt;
   logic [15:0] satHwm;

   int checkCount = 0;
   int errorCount = 0;

   stb_occ_mon dut (
      .clk        (clock),
      .rst_l      (resetL),
      .enable     (enable),
      .coreid     (coreId),
      .stb_cnt    (stbCnt),
      .stb_rst    (stbRst),
      .hwm_clr    (hwmClr),
      .err_vld    (errVld),
      .err_thr    (errThr),
      .err_code   (errCode),
      .err_sticky (errSticky),
      .err_cnt    (errCnt),
      .hwm        (hwm)
   );

   stb_occ_mon #(.ERRCNT_W(4)) dutSat (
      .clk        (clock),
      .rst_l      (resetL),
      .enable     (enable),
      .coreid     (coreId),
      .stb_cnt    (stbCnt),
      .stb_rst    (stbRst),
      .hwm_clr    (hwmClr),
      .err_vld    (satErrVld),
      .err_thr    (satErrThr),
      .err_code   (satErrCode),
      .err_sticky (satErrSticky),
      .err_cnt    (satErrCnt),
      .hwm        (satHwm)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of counts (nibble t = thread t) and stb_rst, then settle past the edge.
   task automatic applyStimulus(input logic [15:0] cntVec, input logic [3:0] rstVec);
      stbCnt = cntVec;
      stbRst = rstVec;
      @(posedge clock);
      #1;
   endtask

   // All outputs of both instances must be zero.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_vld"},     errVld,       0);
      checkOutput({tag, "_thr"},     errThr,       0);
      checkOutput({tag, "_code"},    errCode,      0);
      checkOutput({tag, "_sticky"},  errSticky,    0);
      checkOutput({tag, "_cnt"},     errCnt,       0);
      checkOutput({tag, "_hwm"},     hwm,          0);
      checkOutput({tag, "_satvld"},  satErrVld,    0);
      checkOutput({tag, "_satcnt"},  satErrCnt,    0);
      checkOutput({tag, "_satstk"},  satErrSticky, 0);
      checkOutput({tag, "_sathwm"},  satHwm,       0);
   endtask

   // Full reset with idle inputs, then let the post-reset blanking cycle go by.
   task automatic doReset(input string tag);
      stbCnt = '0;
      stbRst = '0;
      hwmClr = 1'b0;
      enable = 1'b1;
      resetL = 1'b0;
      #2;
      checkResetState(tag);
      @(posedge clock);
      #1;
      resetL = 1'b1;
      applyStimulus(16'h0000, 4'h0);
   endtask

   // Directed scenario sequence.
   initial begin
      clock  = 1'b0;
      resetL = 1'b0;
      enable = 1'b1;
      coreId = 10'h2A;
      stbCnt = '0;
      stbRst = '0;
      hwmClr = 1'b0;
      #2;
      checkResetState("por");
      @(posedge clock);
      #1;
      resetL = 1'b1;

      // Thread-reset pulse well ahead of the ramp, then idle.
      applyStimulus(16'h0000, 4'hF);
      applyStimulus(16'h0000, 4'h0);
      applyStimulus(16'h0000, 4'h0);
      applyStimulus(16'h0000, 4'h0);
      checkOutput("idle_vld", errVld, 0);

      // Ramp thread 2 from 0 up to 9; only the 9 is an overflow.
      for (int v = 0; v <= 8; v++) begin
         applyStimulus(16'(v) << 8, 4'h0);
         checkOutput("ramp_quiet", errVld, 0);
      end
      applyStimulus(16'h0900, 4'h0);
      checkOutput("ramp_vld",    errVld,    1);
      checkOutput("ramp_thr",    errThr,    2);
      checkOutput("ramp_code",   errCode,   2'b01);
      checkOutput("ramp_sticky", errSticky, 4'b0100);
      checkOutput("ramp_cnt",    errCnt,    1);
      checkOutput("ramp_hwm",    hwm,       16'h0900);

      // Dropping thread 2 back to 0 under stb_rst is suppressed.
      applyStimulus(16'h0000, 4'b0100);
      checkOutput("t2drop_vld", errVld, 0);
      applyStimulus(16'h0000, 4'h0);
      checkOutput("t2blank_vld", errVld, 0);

      // Thread 0 held at 12 across a one-cycle stb_rst pulse.
      applyStimulus(16'h000C, 4'b0001);
      checkOutput("blank_k",  errVld, 0);
      applyStimulus(16'h000C, 4'h0);
      checkOutput("blank_k1", errVld, 0);
      applyStimulus(16'h000C, 4'h0);
      checkOutput("blank_k2_vld",  errVld,    1);
      checkOutput("blank_k2_thr",  errThr,    0);
      checkOutput("blank_k2_code", errCode,   2'b01);
      checkOutput("blank_k2_cnt",  errCnt,    2);
      checkOutput("blank_k2_stk",  errSticky, 4'b0101);
      applyStimulus(16'h0000, 4'b0001);
      applyStimulus(16'h0000, 4'h0);
      checkOutput("t0clean_vld", errVld, 0);

      // Thread 1: step-only, step plus overflow, then overflow-only.
      applyStimulus(16'h0030, 4'b0010);
      applyStimulus(16'h0030, 4'h0);
      applyStimulus(16'h0030, 4'h0);
      checkOutput("step_hold", errVld, 0);
      applyStimulus(16'h0060, 4'h0);
      checkOutput("step_vld",  errVld,  1);
      checkOutput("step_thr",  errThr,  1);
      checkOutput("step_code", errCode, 2'b10);
      applyStimulus(16'h0070, 4'h0);
      checkOutput("step_ok_vld",  errVld,  0);
      checkOutput("step_ok_thr",  errThr,  0);
      checkOutput("step_ok_code", errCode, 0);
      applyStimulus(16'h00A0, 4'h0);
      checkOutput("both_code", errCode, 2'b11);
      checkOutput("both_thr",  errThr,  1);
      applyStimulus(16'h00A0, 4'h0);
      checkOutput("ovonly_code", errCode,   2'b01);
      checkOutput("ovonly_cnt",  errCnt,    5);
      checkOutput("ovonly_stk",  errSticky, 4'b0111);
      applyStimulus(16'h0000, 4'b0010);
      applyStimulus(16'h0000, 4'h0);

      // Threads 1 and 3 overflow together.
      doReset("rst4");
      applyStimulus(16'h8080, 4'b1010);
      applyStimulus(16'h8080, 4'h0);
      applyStimulus(16'h8080, 4'h0);
      checkOutput("dual_pre", errVld, 0);
      applyStimulus(16'h9090, 4'h0);
      checkOutput("dual_vld",  errVld,    1);
      checkOutput("dual_thr",  errThr,    1);
      checkOutput("dual_code", errCode,   2'b01);
      checkOutput("dual_stk",  errSticky, 4'b1010);
      checkOutput("dual_cnt",  errCnt,    2);

      // Reporting disabled: no error, but the high-water mark still moves; then clear it.
      doReset("rst5");
      enable = 1'b0;
      applyStimulus(16'hF000, 4'b1000);
      applyStimulus(16'hF000, 4'h0);
      applyStimulus(16'hF000, 4'h0);
      checkOutput("dis_vld", errVld,    0);
      checkOutput("dis_stk", errSticky, 0);
      checkOutput("dis_cnt", errCnt,    0);
      checkOutput("dis_hwm", hwm,       16'hF000);
      hwmClr = 1'b1;
      applyStimulus(16'hF000, 4'h0);
      hwmClr = 1'b0;
      checkOutput("hwmclr", hwm, 0);
      applyStimulus(16'h0000, 4'b1000);
      enable = 1'b1;
      applyStimulus(16'h0000, 4'h0);

      // Long overflow run: the 4-bit counter saturates and holds.
      doReset("rst6");
      applyStimulus(16'h000C, 4'b0001);
      applyStimulus(16'h000C, 4'h0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(16'h000C, 4'h0);
      end
      checkOutput("sat_cnt",  satErrCnt, 4'hF);
      checkOutput("wide_cnt", errCnt,    20);
      applyStimulus(16'h000C, 4'h0);
      checkOutput("sat_hold", satErrCnt, 4'hF);
      checkOutput("wide_21",  errCnt,    21);

      // Asynchronous reset in the middle of the error stream.
      #2;
      resetL = 1'b0;
      #1;
      checkResetState("async");
      @(posedge clock);
      #1;
      resetL = 1'b1;
      applyStimulus(16'h000C, 4'h0);
      checkOutput("postrst_blank", satErrVld, 0);
      checkOutput("postrst_hwm",   satHwm,    0);
      applyStimulus(16'h000C, 4'h0);
      checkOutput("postrst_vld",  satErrVld,  1);
      checkOutput("postrst_code", satErrCode, 2'b01);
      checkOutput("postrst_cnt",  satErrCnt,  1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
